// File: rtl/branch_resolve_bht.sv
// Branch resolution unit with a 2-bit saturating-counter BHT.
// Resolves B-type compares, trains the BHT, registers redirect info.
module branch_resolve_bht #(
  parameter int         n        = 32,
  parameter int         ENTRIES  = 16,
  parameter logic [1:0] CNT_INIT = 2'b01,
  parameter int         CW       = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [n-1:0]  f_pc,
  output logic          f_predtaken,
  input  logic          ex_valid,
  input  logic          ex_isbranch,
  input  logic          ex_stall,
  input  logic [n-1:0]  ex_pc,
  input  logic [n-1:0]  A,
  input  logic [n-1:0]  B,
  input  logic [2:0]    brfunc,
  input  logic          ex_predtaken,
  input  logic [n-1:0]  ex_target,
  input  logic [n-1:0]  ex_pcplus4,
  output logic          r_valid,
  output logic          r_taken,
  output logic          r_mispredict,
  output logic [n-1:0]  r_redirect,
  output logic          r_illegal,
  output logic [CW-1:0] br_count,
  output logic [CW-1:0] mp_count
);

  localparam int IDXW = $clog2(ENTRIES);
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]      bht_q [ENTRIES];
  logic [1:0]      bht_d [ENTRIES];
  logic [IDXW-1:0] f_idx;
  logic [IDXW-1:0] ex_idx;
  logic [1:0]      cnt;
  logic            taken;
  logic            illegal;
  logic            resolve;
  logic            mispredict;

  logic            r_valid_q, r_valid_d;
  logic            r_taken_q, r_taken_d;
  logic            r_mp_q, r_mp_d;
  logic [n-1:0]    r_redir_q, r_redir_d;
  logic            r_ill_q, r_ill_d;
  logic [CW-1:0]   br_q, br_d;
  logic [CW-1:0]   mp_q, mp_d;

  logic            unused_pc_bits;

  assign unused_pc_bits = ^{f_pc[n-1:IDXW+2], f_pc[1:0],
                            ex_pc[n-1:IDXW+2], ex_pc[1:0]};

  assign f_idx       = f_pc[IDXW+1:2];
  assign ex_idx      = ex_pc[IDXW+1:2];
  assign f_predtaken = bht_q[f_idx][1];
  assign cnt         = bht_q[ex_idx];
  assign resolve     = ex_valid & ex_isbranch & ~ex_stall;
  assign mispredict  = taken ^ ex_predtaken;

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (brfunc)
      3'b000: taken = (A == B);
      3'b001: taken = (A != B);
      3'b100: taken = ($signed(A) <  $signed(B));
      3'b101: taken = ($signed(A) >= $signed(B));
      3'b110: taken = (A <  B);
      3'b111: taken = (A >= B);
      3'b010,
      3'b011: illegal = 1'b1;
    endcase
  end

  // Fetch reads bht_q directly, so a same-index update is not bypassed.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) bht_d[i] = bht_q[i];
    if (resolve && !illegal) begin
      if (taken)
        bht_d[ex_idx] = (cnt == 2'b11) ? cnt : cnt + 2'd1;
      else
        bht_d[ex_idx] = (cnt == 2'b00) ? cnt : cnt - 2'd1;
    end
  end

  always_comb begin
    r_valid_d = r_valid_q;
    r_taken_d = r_taken_q;
    r_mp_d    = r_mp_q;
    r_redir_d = r_redir_q;
    r_ill_d   = r_ill_q;
    if (!ex_stall) begin
      if (ex_valid && ex_isbranch) begin
        r_valid_d = 1'b1;
        r_taken_d = taken;
        r_mp_d    = mispredict;
        r_redir_d = taken ? ex_target : ex_pcplus4;
        r_ill_d   = illegal;
      end else begin
        r_valid_d = 1'b0;
        r_mp_d    = 1'b0;
        r_ill_d   = 1'b0;
      end
    end
  end

  always_comb begin
    br_d = br_q;
    mp_d = mp_q;
    if (resolve && br_q != '1) br_d = br_q + ONE;
    if (resolve && mispredict && mp_q != '1) mp_d = mp_q + ONE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_INIT;
      r_valid_q <= 1'b0;
      r_taken_q <= 1'b0;
      r_mp_q    <= 1'b0;
      r_redir_q <= '0;
      r_ill_q   <= 1'b0;
      br_q      <= '0;
      mp_q      <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= bht_d[i];
      r_valid_q <= r_valid_d;
      r_taken_q <= r_taken_d;
      r_mp_q    <= r_mp_d;
      r_redir_q <= r_redir_d;
      r_ill_q   <= r_ill_d;
      br_q      <= br_d;
      mp_q      <= mp_d;
    end
  end

  assign r_valid      = r_valid_q;
  assign r_taken      = r_taken_q;
  assign r_mispredict = r_mp_q;
  assign r_redirect   = r_redir_q;
  assign r_illegal    = r_ill_q;
  assign br_count     = br_q;
  assign mp_count     = mp_q;

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Testbench for branch_resolve_bht: vector table + scoreboard queue,
// hand sequences for training, aliasing, stall, saturation and reset.
module tb_branch_resolve_bht;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] f_pc;
  logic        f_predtaken;
  logic        ex_valid, ex_isbranch, ex_stall;
  logic [31:0] ex_pc, A, B;
  logic [2:0]  brfunc;
  logic        ex_predtaken;
  logic [31:0] ex_target, ex_pcplus4;
  logic        r_valid, r_taken, r_mispredict, r_illegal;
  logic [31:0] r_redirect;
  logic [3:0]  br_count, mp_count;

  branch_resolve_bht #(.n(32), .ENTRIES(16), .CNT_INIT(2'b01), .CW(4)) dut (
    .clock(clock), .reset(reset), .f_pc(f_pc), .f_predtaken(f_predtaken),
    .ex_valid(ex_valid), .ex_isbranch(ex_isbranch), .ex_stall(ex_stall),
    .ex_pc(ex_pc), .A(A), .B(B), .brfunc(brfunc),
    .ex_predtaken(ex_predtaken), .ex_target(ex_target),
    .ex_pcplus4(ex_pcplus4), .r_valid(r_valid), .r_taken(r_taken),
    .r_mispredict(r_mispredict), .r_redirect(r_redirect),
    .r_illegal(r_illegal), .br_count(br_count), .mp_count(mp_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        taken;
    logic        mp;
    logic        ill;
    logic [31:0] redir;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic        pred;
    logic        etaken;
    logic        eill;
  } vec_t;

  exp_t sbq[$];
  vec_t vecs[10];

  int errors = 0;
  int checks = 0;
  int exp_br = 0;
  int exp_mp = 0;
  exp_t last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f,
                       input logic pred, input logic stall);
    ex_valid     = 1'b1;
    ex_isbranch  = 1'b1;
    ex_stall     = stall;
    ex_pc        = pc;
    A            = a;
    B            = b;
    brfunc       = f;
    ex_predtaken = pred;
    ex_target    = pc + 32'h100;
    ex_pcplus4   = pc + 32'h4;
  endtask

  // pre[1]=1 checks f_predtaken against pre[0] before the update edge
  task automatic resolve(input string nm, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic pred,
                         input logic etaken, input logic eill,
                         input logic [1:0] pre);
    exp_t e;
    exp_t got;
    drive(pc, a, b, f, pred, 1'b0);
    e.taken = etaken;
    e.ill   = eill;
    e.mp    = etaken ^ pred;
    e.redir = etaken ? pc + 32'h100 : pc + 32'h4;
    sbq.push_back(e);
    if (pre[1]) begin
      #1;
      chk({nm, "_same_cycle"}, {31'b0, f_predtaken}, {31'b0, pre[0]});
    end
    @(posedge clock);
    #1;
    if (exp_br < 15) exp_br++;
    if (e.mp && exp_mp < 15) exp_mp++;
    if (sbq.size() == 0) begin
      chk({nm, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got  = sbq.pop_front();
      last = got;
      chk({nm, "_valid"}, {31'b0, r_valid}, 32'd1);
      chk({nm, "_taken"}, {31'b0, r_taken}, {31'b0, got.taken});
      chk({nm, "_mp"}, {31'b0, r_mispredict}, {31'b0, got.mp});
      chk({nm, "_ill"}, {31'b0, r_illegal}, {31'b0, got.ill});
      chk({nm, "_redir"}, r_redirect, got.redir);
    end
    chk({nm, "_br"}, {28'b0, br_count}, exp_br);
    chk({nm, "_mp_cnt"}, {28'b0, mp_count}, exp_mp);
  endtask

  task automatic pred_at(input string nm, input logic [31:0] pc,
                         input logic exp);
    f_pc = pc;
    #1;
    chk(nm, {31'b0, f_predtaken}, {31'b0, exp});
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'd1, 3'b100, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'd1, 3'b110, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'd1, 3'b101, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFF_FFFF, 32'd1, 3'b111, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'd5, 32'd5, 3'b001, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{32'd3, 32'd7, 3'b001, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{32'd1, 32'hFFFF_FFFF, 3'b110, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{32'd9, 32'd9, 3'b010, 1'b0, 1'b0, 1'b1};
    vecs[9] = '{32'd7, 32'd3, 3'b011, 1'b1, 1'b0, 1'b1};

    reset        = 1'b1;
    f_pc         = 32'h100;
    ex_valid     = 1'b0;
    ex_isbranch  = 1'b0;
    ex_stall     = 1'b0;
    ex_pc        = '0;
    A            = '0;
    B            = '0;
    brfunc       = '0;
    ex_predtaken = 1'b0;
    ex_target    = '0;
    ex_pcplus4   = '0;
    #2;
    chk("rst_pred", {31'b0, f_predtaken}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("rst_valid", {31'b0, r_valid}, 32'd0);
    chk("rst_taken", {31'b0, r_taken}, 32'd0);
    chk("rst_mp", {31'b0, r_mispredict}, 32'd0);
    chk("rst_ill", {31'b0, r_illegal}, 32'd0);
    chk("rst_redir", r_redirect, 32'd0);
    chk("rst_br", {28'b0, br_count}, 32'd0);
    chk("rst_mp_cnt", {28'b0, mp_count}, 32'd0);

    // compare types; pcs map to BHT indices 1..10
    for (int i = 0; i < 10; i++)
      resolve($sformatf("vec%0d", i), 32'h204 + 32'(4 * i), vecs[i].a,
              vecs[i].b, vecs[i].f, vecs[i].pred, vecs[i].etaken,
              vecs[i].eill, 2'b00);

    ex_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("idle_valid", {31'b0, r_valid}, 32'd0);
    chk("idle_mp", {31'b0, r_mispredict}, 32'd0);
    chk("idle_ill", {31'b0, r_illegal}, 32'd0);
    chk("idle_taken_hold", {31'b0, r_taken}, {31'b0, last.taken});
    chk("idle_redir_hold", r_redirect, last.redir);

    resolve("mispred", 32'h504, 32'd7, 32'd7, 3'b000, 1'b0, 1'b1, 1'b0,
            2'b00);

    // training at idx 0: 01 -> 10 -> 11 -> 11 -> 10
    f_pc = 32'h40;
    resolve("train1", 32'h40, 32'd5, 32'd5, 3'b000, 1'b0, 1'b1, 1'b0,
            2'b10);
    pred_at("train1_pred", 32'h40, 1'b1);
    resolve("train2", 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0,
            2'b11);
    pred_at("train2_pred", 32'h40, 1'b1);
    resolve("train3", 32'h40, 32'd5, 32'd5, 3'b000, 1'b1, 1'b1, 1'b0,
            2'b11);
    resolve("train_nt", 32'h40, 32'd5, 32'd5, 3'b001, 1'b1, 1'b0, 1'b0,
            2'b11);
    pred_at("train_nt_pred", 32'h40, 1'b1);

    // illegal funct3 must not train (counter stays 10)
    resolve("ill1", 32'h40, 32'd0, 32'd0, 3'b010, 1'b1, 1'b0, 1'b1, 2'b00);
    resolve("ill2", 32'h40, 32'd0, 32'd0, 3'b011, 1'b1, 1'b0, 1'b1, 2'b00);
    pred_at("ill_no_train", 32'h40, 1'b1);
    pred_at("alias_pred", 32'h80, 1'b1);

    // stalled not-taken branches: no training, r_* hold
    drive(32'h80, 32'd5, 32'd5, 3'b001, 1'b0, 1'b1);
    repeat (2) @(posedge clock);
    #1;
    chk("stall_valid", {31'b0, r_valid}, 32'd1);
    chk("stall_taken", {31'b0, r_taken}, {31'b0, last.taken});
    chk("stall_mp", {31'b0, r_mispredict}, {31'b0, last.mp});
    chk("stall_ill", {31'b0, r_illegal}, {31'b0, last.ill});
    chk("stall_redir", r_redirect, last.redir);
    chk("stall_br", {28'b0, br_count}, exp_br);
    pred_at("stall_no_train", 32'h40, 1'b1);

    // alias 0x80 trains idx 0: 10 -> 01
    resolve("alias_nt", 32'h80, 32'd5, 32'd5, 3'b001, 1'b1, 1'b0, 1'b0,
            2'b00);
    pred_at("alias_nt_pred", 32'h40, 1'b0);

    for (int i = 0; i < 20; i++)
      resolve($sformatf("sat%0d", i), 32'h304, 32'd1, 32'd2, 3'b000, 1'b0,
              1'b0, 1'b0, 2'b00);
    chk("sat_br15", {28'b0, br_count}, 32'd15);

    // idx 15: 01 -> 10 -> 11, then async reset mid-update
    resolve("pre_rst1", 32'h3C, 32'd1, 32'd1, 3'b000, 1'b1, 1'b1, 1'b0,
            2'b00);
    resolve("pre_rst2", 32'h3C, 32'd1, 32'd1, 3'b000, 1'b0, 1'b1, 1'b0,
            2'b00);
    pred_at("pre_rst_pred", 32'h3C, 1'b1);
    drive(32'h3C, 32'd1, 32'd2, 3'b000, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    sbq.delete();
    chk("mid_rst_pred", {31'b0, f_predtaken}, 32'd0);
    chk("mid_rst_valid", {31'b0, r_valid}, 32'd0);
    chk("mid_rst_taken", {31'b0, r_taken}, 32'd0);
    chk("mid_rst_redir", r_redirect, 32'd0);
    chk("mid_rst_br", {28'b0, br_count}, 32'd0);
    chk("mid_rst_mp", {28'b0, mp_count}, 32'd0);
    ex_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst_br", {28'b0, br_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
